// File: rtl/output_signature_reducer_pkg.sv
// Shared definitions for the output capture block: FSM states, default MISR
// constants and a constant-evaluable ceiling log2.
package out_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } cap_state_t;

  localparam logic [31:0] DEF_SIG_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SIG_SEED = 32'hFFFFFFFF;

  // Ceiling log2; clog2(1) = 0 so a single channel needs no tree levels.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_signature_reducer_xor_fold_lane.sv
// One kernel output channel: registers the write strobe and the XOR of all
// OUT_WIDTH-bit slices of the channel word.
module xor_fold_lane #(
  parameter int DIN_WIDTH = 32,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIN_WIDTH-1:0] i_din,
  input  logic                 i_write,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_fold
);

  localparam int SLICES = DIN_WIDTH / OUT_WIDTH;

  logic [OUT_WIDTH-1:0] w_fold;
  logic                 r_valid;
  logic [OUT_WIDTH-1:0] r_fold;

  // Fold the word down to pin width by XOR-ing every slice together.
  always_comb begin
    w_fold = '0;
    for (int s = 0; s < SLICES; s++) begin
      w_fold = w_fold ^ i_din[s*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Stage 1 register: the fold runs every cycle, the valid marks real writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_fold  <= '0;
    end else begin
      r_valid <= i_write;
      r_fold  <= w_fold;
    end
  end

  assign o_valid = r_valid;
  assign o_fold  = r_fold;

endmodule

// File: rtl/output_signature_reducer.sv
// Output capture stage: folds NUM_CH kernel output channels into an
// OUT_WIDTH-bit pin stream through a registered XOR tree, and frames each
// kernel run with a MISR signature, a write count and a count check.
module output_signature_reducer
  import out_capture_pkg::*;
#(
  parameter int                   NUM_CH         = 2,
  parameter int                   DIN_WIDTH      = 32,
  parameter int                   OUT_WIDTH      = 4,
  parameter int                   SIG_WIDTH      = 32,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY       = SIG_WIDTH'(DEF_SIG_POLY),
  parameter logic [SIG_WIDTH-1:0] SIG_SEED       = SIG_WIDTH'(DEF_SIG_SEED),
  parameter int                   EXPECTED_WORDS = 4096
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  input  logic                        ap_done,
  input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]           ch_write,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_valid,
  output logic [SIG_WIDTH-1:0]        signature,
  output logic [31:0]                 word_count,
  output logic                        sig_valid,
  output logic                        count_error
);

  localparam int LEVELS     = clog2(NUM_CH);
  localparam int DRAIN_LAST = LEVELS + 1;
  localparam int DCW        = clog2(LEVELS + 3);

  // Number of live nodes at a tree level; level 0 is the lane outputs.
  function automatic int nodes(input int l);
    return (NUM_CH + (1 << l) - 1) >> l;
  endfunction

  // Saturating word-count accumulate.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFFFFFF : s[31:0];
  endfunction

  // One MISR shift with the current pin beat folded in.
  function automatic logic [SIG_WIDTH-1:0] misr_step(input logic [SIG_WIDTH-1:0] s,
                                                     input logic [OUT_WIDTH-1:0] d);
    return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? SIG_POLY : '0) ^ SIG_WIDTH'(d);
  endfunction

  logic [NUM_CH-1:0]    w_lane_v;
  logic [OUT_WIDTH-1:0] w_lane_d [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    xor_fold_lane #(
      .DIN_WIDTH (DIN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .i_clk   (ap_clk),
      .i_rst   (ap_rst),
      .i_din   (ch_din[g*DIN_WIDTH +: DIN_WIDTH]),
      .i_write (ch_write[g]),
      .o_valid (w_lane_v[g]),
      .o_fold  (w_lane_d[g])
    );
  end

  // Tree storage: entry l holds the registered output of level l (l >= 1);
  // entry 0 is unused because level 0 comes straight from the lanes.
  logic [NUM_CH-1:0]    r_tv [LEVELS+1];
  logic [OUT_WIDTH-1:0] r_td [LEVELS+1][NUM_CH];
  logic [NUM_CH-1:0]    w_sv [LEVELS+1];
  logic [OUT_WIDTH-1:0] w_sd [LEVELS+1][NUM_CH];

  // Gather every level's source values into one indexable view.
  always_comb begin
    w_sv[0] = w_lane_v;
    for (int j = 0; j < NUM_CH; j++) begin
      w_sd[0][j] = w_lane_d[j];
    end
    for (int l = 1; l <= LEVELS; l++) begin
      w_sv[l] = r_tv[l];
      for (int j = 0; j < NUM_CH; j++) begin
        w_sd[l][j] = r_td[l][j];
      end
    end
  end

  // Registered binary XOR tree; invalid children contribute zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int l = 0; l <= LEVELS; l++) begin
        r_tv[l] <= '0;
        for (int j = 0; j < NUM_CH; j++) begin
          r_td[l][j] <= '0;
        end
      end
    end else begin
      r_tv[0] <= '0;
      for (int j = 0; j < NUM_CH; j++) begin
        r_td[0][j] <= '0;
      end
      for (int l = 1; l <= LEVELS; l++) begin
        for (int j = 0; j < NUM_CH; j++) begin
          if (2*j + 1 < nodes(l-1)) begin
            r_tv[l][j] <= w_sv[l-1][2*j] | w_sv[l-1][2*j+1];
            r_td[l][j] <= (w_sv[l-1][2*j]   ? w_sd[l-1][2*j]   : '0) ^
                          (w_sv[l-1][2*j+1] ? w_sd[l-1][2*j+1] : '0);
          end else if (2*j < nodes(l-1)) begin
            r_tv[l][j] <= w_sv[l-1][2*j];
            r_td[l][j] <= w_sv[l-1][2*j] ? w_sd[l-1][2*j] : '0;
          end else begin
            r_tv[l][j] <= 1'b0;
            r_td[l][j] <= '0;
          end
        end
      end
    end
  end

  logic                 w_root_v;
  logic [OUT_WIDTH-1:0] w_root_d;

  // Root of the tree: only node 0 is live at the top level, the rest are
  // constant zero, so reducing over all of them yields node 0's value.
  always_comb begin
    w_root_v = |w_sv[LEVELS];
    w_root_d = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (w_sv[LEVELS][j]) begin
        w_root_d = w_root_d ^ w_sd[LEVELS][j];
      end
    end
  end

  logic                 r_data_valid;
  logic [OUT_WIDTH-1:0] r_data_out;

  // Final output register feeding the pins.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_data_valid <= w_root_v;
      r_data_out   <= w_root_d;
    end
  end

  cap_state_t     r_state;
  cap_state_t     w_next;
  logic           w_report;
  logic [DCW-1:0] r_drain_cnt;

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Run framing: start -> run -> pipeline drain -> single-cycle report.
  always_comb begin
    w_next   = r_state;
    w_report = 1'b0;
    case (r_state)
      ST_IDLE:   if (ap_start) w_next = ST_RUN;
      ST_RUN:    if (ap_done) w_next = ST_DRAIN;
      ST_DRAIN:  if (r_drain_cnt == DCW'(DRAIN_LAST)) w_next = ST_REPORT;
      ST_REPORT: begin
        w_report = 1'b1;
        w_next   = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  logic [31:0] w_pop;

  // Number of channel writes presented this cycle.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + 32'(ch_write[i]);
    end
  end

  logic [SIG_WIDTH-1:0] r_sig;
  logic [31:0]          r_word_count;
  logic                 r_count_error;

  // Per-run signature, write count, drain timer and count check.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_sig         <= '0;
      r_word_count  <= '0;
      r_count_error <= 1'b0;
      r_drain_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_sig         <= SIG_SEED;
            r_word_count  <= '0;
            r_count_error <= 1'b0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          r_word_count <= sat_add(r_word_count, w_pop);
          if (r_data_valid) begin
            r_sig <= misr_step(r_sig, r_data_out);
          end
          r_drain_cnt <= (r_state == ST_RUN) ? '0 : r_drain_cnt + 1'b1;
        end
        ST_REPORT: begin
          r_count_error <= (r_word_count != 32'(EXPECTED_WORDS));
        end
        default: ;
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign signature   = r_sig;
  assign word_count  = r_word_count;
  assign sig_valid   = w_report;
  assign count_error = r_count_error;

endmodule
